// File: rtl/cmd_exec_fsm_pkg.sv
// Shared encodings for the command executor: FSM states, command word fields
// and status word bit positions.
package cmd_exec_fsm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CLR  = 2'd2
   } state_t;

   localparam int CMD_START   = 0;
   localparam int CMD_ABORT   = 1;
   localparam int CMD_OP_LSB  = 4;
   localparam int CMD_CNT_LSB = 16;
   localparam int OP_WIDTH    = 4;

   localparam int STA_BUSY     = 0;
   localparam int STA_DONE     = 1;
   localparam int STA_ERR_LEN0 = 2;
   localparam int STA_ERR_TMO  = 3;
   localparam int STA_ABORT    = 4;
   localparam int STA_OP_LSB   = 8;
   localparam int STA_CNT_LSB  = 16;

   // Sticky completion flags, cleared only when a new command is accepted.
   typedef struct packed {
      logic aborted;
      logic err_tmo;
      logic err_len0;
      logic done;
   } sticky_t;

endpackage

// File: rtl/cmd_tmo_cnt.sv
// Stall timeout counter: counts consecutive stalled cycles and flags the cycle
// in which the count reaches its all-ones limit.
module cmd_tmo_cnt #(
   parameter int TMO_WIDTH = 16
) (
   input  logic clks,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic expire
);

   localparam logic [TMO_WIDTH-1:0] TMO_MAX  = '1;
   localparam logic [TMO_WIDTH-1:0] TMO_ONE  = TMO_WIDTH'(1);
   localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_MAX - TMO_ONE;

   logic [TMO_WIDTH-1:0] cnt_reg;
   logic [TMO_WIDTH-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (clr) begin
         cnt_next = '0;
      end else if (inc && (cnt_reg != TMO_MAX)) begin
         cnt_next = cnt_reg + TMO_ONE;
      end
   end

   always_ff @(posedge clks or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   // Fires on the stalled cycle that brings the count to all-ones.
   assign expire = inc && !clr && (cnt_reg == TMO_LAST);

endmodule

// File: rtl/cmd_exec_fsm.sv
// Command executor: decodes the CPU command word, runs a beat-counted
// valid/ready transaction to the engine and pulses the command clear when done.
module cmd_exec_fsm
   import cmd_exec_fsm_pkg::*;
#(
   parameter int TMO_WIDTH = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                clks,
   input  logic                reset,
   input  logic [31:0]         cmd_din,
   output logic                cmd_clr,
   output logic                op_vld,
   input  logic                op_rdy,
   output logic [OP_WIDTH-1:0] op_code,
   output logic                op_last,
   output logic [31:0]         sta_dout
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t                state_reg, state_next;
   logic                  op_vld_reg, op_vld_next;
   logic                  op_last_reg, op_last_next;
   logic [OP_WIDTH-1:0]   op_code_reg, op_code_next;
   logic                  cmd_clr_reg, cmd_clr_next;
   logic                  busy_reg, busy_next;
   sticky_t               sticky_reg, sticky_next;
   logic [CNT_WIDTH-1:0]  count_reg, count_next;
   logic [CNT_WIDTH-1:0]  beat_cnt_reg, beat_cnt_next;

   logic                  cmd_start;
   logic                  cmd_abort;
   logic [OP_WIDTH-1:0]   cmd_op;
   logic [CNT_WIDTH-1:0]  cmd_cnt;
   logic                  cmd_unused;
   logic                  hs;
   logic                  stall;
   logic                  tmo_clr;
   logic                  tmo_expire;
   logic [CNT_WIDTH-1:0]  beat_inc;
   logic [CNT_WIDTH-1:0]  count_m1;

   assign cmd_start  = cmd_din[CMD_START];
   assign cmd_abort  = cmd_din[CMD_ABORT];
   assign cmd_op     = cmd_din[CMD_OP_LSB +: OP_WIDTH];
   assign cmd_cnt    = cmd_din[CMD_CNT_LSB +: CNT_WIDTH];
   // Reserved command bits carry no meaning here.
   assign cmd_unused = ^cmd_din;

   assign hs       = op_vld_reg & op_rdy;
   assign stall    = op_vld_reg & ~op_rdy;
   assign tmo_clr  = hs | ~op_vld_reg;
   assign beat_inc = beat_cnt_reg + CNT_ONE;
   assign count_m1 = count_reg - CNT_ONE;

   cmd_tmo_cnt #(
      .TMO_WIDTH (TMO_WIDTH)
   ) u_tmo (
      .clks   (clks),
      .reset  (reset),
      .inc    (stall),
      .clr    (tmo_clr),
      .expire (tmo_expire)
   );

   always_comb begin
      state_next    = state_reg;
      op_vld_next   = op_vld_reg;
      op_last_next  = op_last_reg;
      op_code_next  = op_code_reg;
      cmd_clr_next  = 1'b0;
      busy_next     = busy_reg;
      sticky_next   = sticky_reg;
      count_next    = count_reg;
      beat_cnt_next = beat_cnt_reg;

      case (state_reg)
         IDLE: begin
            if (cmd_start) begin
               op_code_next  = cmd_op;
               count_next    = cmd_cnt;
               beat_cnt_next = '0;
               sticky_next   = '0;
               if (cmd_cnt != '0) begin
                  state_next   = RUN;
                  op_vld_next  = 1'b1;
                  op_last_next = (cmd_cnt == CNT_ONE);
                  busy_next    = 1'b1;
               end else begin
                  sticky_next.done     = 1'b1;
                  sticky_next.err_len0 = 1'b1;
                  state_next           = CLR;
                  cmd_clr_next         = 1'b1;
               end
            end else if (cmd_abort) begin
               state_next   = CLR;
               cmd_clr_next = 1'b1;
            end
         end

         RUN: begin
            if (hs) begin
               beat_cnt_next = beat_inc;
               op_last_next  = (beat_inc == count_m1);
            end
            // Abort outranks timeout, which outranks normal completion.
            if (cmd_abort || tmo_expire || (hs && op_last_reg)) begin
               state_next       = CLR;
               cmd_clr_next     = 1'b1;
               op_vld_next      = 1'b0;
               op_last_next     = 1'b0;
               busy_next        = 1'b0;
               sticky_next.done = 1'b1;
               if (cmd_abort) begin
                  sticky_next.aborted = 1'b1;
               end else if (tmo_expire) begin
                  sticky_next.err_tmo = 1'b1;
               end
            end
         end

         CLR: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clks or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         op_vld_reg   <= 1'b0;
         op_last_reg  <= 1'b0;
         op_code_reg  <= '0;
         cmd_clr_reg  <= 1'b0;
         busy_reg     <= 1'b0;
         sticky_reg   <= '0;
         count_reg    <= '0;
         beat_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         op_vld_reg   <= op_vld_next;
         op_last_reg  <= op_last_next;
         op_code_reg  <= op_code_next;
         cmd_clr_reg  <= cmd_clr_next;
         busy_reg     <= busy_next;
         sticky_reg   <= sticky_next;
         count_reg    <= count_next;
         beat_cnt_reg <= beat_cnt_next;
      end
   end

   assign cmd_clr = cmd_clr_reg;
   assign op_vld  = op_vld_reg;
   assign op_last = op_last_reg;
   assign op_code = op_code_reg;

   always_comb begin
      sta_dout                              = '0;
      sta_dout[STA_BUSY]                    = busy_reg;
      sta_dout[STA_DONE]                    = sticky_reg.done;
      sta_dout[STA_ERR_LEN0]                = sticky_reg.err_len0;
      sta_dout[STA_ERR_TMO]                 = sticky_reg.err_tmo;
      sta_dout[STA_ABORT]                   = sticky_reg.aborted;
      sta_dout[STA_OP_LSB +: OP_WIDTH]      = op_code_reg;
      sta_dout[STA_CNT_LSB +: CNT_WIDTH]    = beat_cnt_reg;
   end

endmodule

// File: tb/tb_cmd_exec_fsm.sv
// Bench for cmd_exec_fsm: directed scenarios and randomized commands checked
// against a transaction-level model of beats, exit cause and status word.
`timescale 1ns/1ps
module tb_cmd_exec_fsm;

   localparam int TMO_W   = 6;
   localparam int TMO_MAX = (1 << TMO_W) - 1;
   localparam int PAT_LEN = 256;

   logic        clks = 1'b0;
   logic        reset;
   logic [31:0] cmd_din;
   logic        cmd_clr;
   logic        op_vld;
   logic        op_rdy;
   logic [3:0]  op_code;
   logic        op_last;
   logic [31:0] sta_dout;

   logic        cpu_wr;
   logic [31:0] cpu_data;
   logic [31:0] cmd_reg;
   logic [31:0] sta_model;
   bit          rdy [PAT_LEN];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_txn = 0;

   always #5 clks = ~clks;

   // Command register: CPU write beats the clear pulse.
   always @(posedge clks or posedge reset) begin
      if (reset)        cmd_reg <= '0;
      else if (cpu_wr)  cmd_reg <= cpu_data;
      else if (cmd_clr) cmd_reg <= '0;
   end
   assign cmd_din = cmd_reg;

   cmd_exec_fsm #(
      .TMO_WIDTH (TMO_W),
      .CNT_WIDTH (16)
   ) u_dut (
      .clks     (clks),
      .reset    (reset),
      .cmd_din  (cmd_din),
      .cmd_clr  (cmd_clr),
      .op_vld   (op_vld),
      .op_rdy   (op_rdy),
      .op_code  (op_code),
      .op_last  (op_last),
      .sta_dout (sta_dout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fill_rdy(input int pct, input int stall_from);
      for (int i = 0; i < PAT_LEN; i++)
         rdy[i] = (i < stall_from) && ($urandom_range(0, 99) < pct);
   endtask

   // Walk the ready pattern one valid cycle at a time: k is the index of the
   // k-th cycle op_vld is high. cause: 0 done, 1 timeout, 2 abort.
   task automatic predict(input int n, input int abort_k,
                          output int k_exit, output int beats, output int cause);
      int stalls = 0;
      bit fin = 1'b0;
      beats = 0; k_exit = PAT_LEN; cause = 1;
      for (int k = 0; k < PAT_LEN && !fin; k++) begin
         if (rdy[k]) beats++;
         if (k == abort_k) begin
            k_exit = k; cause = 2; fin = 1'b1;
         end else if (rdy[k]) begin
            stalls = 0;
            if (beats == n) begin k_exit = k; cause = 0; fin = 1'b1; end
         end else begin
            stalls++;
            if (stalls == TMO_MAX) begin k_exit = k; cause = 1; fin = 1'b1; end
         end
      end
   endtask

   task automatic run_cmd(input logic [31:0] cmd, input int abort_k, input bit skip_write,
                          input logic [31:0] chain_cmd, input bit chain);
      int n, k_exit, beats, cause, k;
      int vld_seen, hs_seen, clr_seen, last_vld_c, clr_c;
      logic [3:0]  op;
      logic [31:0] exp_sta;
      bit launch;
      n = int'(cmd[31:16]);
      op = cmd[7:4];
      launch = cmd[0] && (n != 0);
      k_exit = -1; beats = 0; cause = 0;
      if (launch) predict(n, abort_k, k_exit, beats, cause);
      if (cmd[0] && n == 0)
         exp_sta = 32'h6 | (32'(op) << 8);
      else if (launch)
         exp_sta = 32'h2 | (cause == 1 ? 32'h8 : 32'h0) | (cause == 2 ? 32'h10 : 32'h0)
                 | (32'(op) << 8) | (32'(beats) << 16);
      else
         exp_sta = sta_model;
      sta_model = exp_sta;

      if (!skip_write) begin
         @(negedge clks);
         cpu_data = cmd;
         cpu_wr = 1'b1;
      end
      vld_seen = 0; hs_seen = 0; clr_seen = 0; last_vld_c = -1; clr_c = -1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clks);
         cpu_wr = 1'b0;
         if (clr_seen != 0) begin
            check("post_vld", 32'(op_vld), 32'h0);
            check("post_clr", 32'(cmd_clr), 32'h0);
            check("post_sta", sta_dout, exp_sta);
            break;
         end
         if (op_vld) begin
            k = vld_seen;
            vld_seen++;
            last_vld_c = c;
            if (k == 0) check("busy_sta", sta_dout, (32'(op) << 8) | 32'h1);
            check("op_code", 32'(op_code), 32'(op));
            check("op_last", 32'(op_last), 32'(hs_seen == n - 1));
            op_rdy = (k < PAT_LEN) ? rdy[k] : 1'b0;
            if (op_rdy) hs_seen++;
            if (abort_k >= 1 && k == abort_k - 1) begin
               cpu_data = cmd | 32'h2;
               cpu_wr = 1'b1;
            end
         end else begin
            op_rdy = 1'($urandom_range(0, 1));
         end
         if (cmd_clr) begin
            clr_seen++;
            clr_c = c;
            check("clr_sta", sta_dout, exp_sta);
            if (chain) begin
               cpu_data = chain_cmd;
               cpu_wr = 1'b1;
               break;
            end
         end
      end
      check("clr_count", clr_seen, 1);
      check("vld_cycles", vld_seen, launch ? k_exit + 1 : 0);
      check("handshakes", hs_seen, launch ? beats : 0);
      if (launch) check("clr_timing", clr_c, last_vld_c + 1);
      n_txn++;
      $display("txn %0d: cmd=%h vld_cycles=%0d beats=%0d clr=%0d sta=%h",
               n_txn, cmd, vld_seen, hs_seen, clr_seen, sta_dout);
   endtask

   initial begin
      logic [31:0] cmd;
      int n, k_nat, b_nat, c_nat, abort_k;
      bit tmo_case;

      reset = 1'b1; cpu_wr = 1'b0; cpu_data = '0; op_rdy = 1'b0; sta_model = '0;
      repeat (3) @(negedge clks);
      check("rst_vld", 32'(op_vld), 32'h0);
      check("rst_clr", 32'(cmd_clr), 32'h0);
      check("rst_code", 32'(op_code), 32'h0);
      check("rst_last", 32'(op_last), 32'h0);
      check("rst_sta", sta_dout, 32'h0);
      reset = 1'b0;
      @(negedge clks);

      fill_rdy(100, PAT_LEN);
      run_cmd(32'h0003_0051, -1, 1'b0, 32'h0, 1'b0);
      check("three_beats_sta", sta_dout, 32'h0003_0502);

      run_cmd(32'h0000_0002, -1, 1'b0, 32'h0, 1'b0);
      check("idle_abort_sta", sta_dout, 32'h0003_0502);

      run_cmd(32'h0000_0031, -1, 1'b0, 32'h0, 1'b0);
      check("len0_sta", sta_dout, 32'h0000_0306);

      fill_rdy(100, 1);
      run_cmd(32'h0004_0011, -1, 1'b0, 32'h0, 1'b0);
      check("timeout_sta", sta_dout, 32'h0001_010A);

      fill_rdy(100, PAT_LEN);
      run_cmd(32'h0008_0071, 2, 1'b0, 32'h0, 1'b0);
      check("run_abort_sta", sta_dout, 32'h0003_0712);

      run_cmd(32'h0002_0091, -1, 1'b0, 32'h0001_00A1, 1'b1);
      run_cmd(32'h0001_00A1, -1, 1'b1, 32'h0, 1'b0);
      check("chain_sta", sta_dout, 32'h0001_0A02);

      for (int t = 0; t < 30; t++) begin
         cmd = $urandom();
         n = $urandom_range(0, 6);
         cmd[31:16] = 16'(n);
         cmd[0] = 1'b1;
         cmd[1] = ($urandom_range(0, 7) == 0);
         tmo_case = ($urandom_range(0, 5) == 0);
         fill_rdy(65, tmo_case ? int'($urandom_range(0, 4)) : 180);
         abort_k = -1;
         if (cmd[1] && n != 0) begin
            abort_k = 0;
         end else if (n != 0 && $urandom_range(0, 3) == 0) begin
            predict(n, -1, k_nat, b_nat, c_nat);
            if (k_nat >= 1) abort_k = $urandom_range(1, k_nat);
         end
         run_cmd(cmd, abort_k, 1'b0, 32'h0, 1'b0);
      end

      @(negedge clks);
      op_rdy = 1'b0;
      cpu_data = 32'h0005_0021;
      cpu_wr = 1'b1;
      @(negedge clks);
      cpu_wr = 1'b0;
      @(negedge clks);
      check("pre_rst_vld", 32'(op_vld), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("async_vld", 32'(op_vld), 32'h0);
      check("async_clr", 32'(cmd_clr), 32'h0);
      check("async_code", 32'(op_code), 32'h0);
      check("async_last", 32'(op_last), 32'h0);
      check("async_sta", sta_dout, 32'h0);
      @(negedge clks);
      reset = 1'b0;
      sta_model = '0;
      repeat (3) begin
         @(negedge clks);
         check("idle_vld", 32'(op_vld), 32'h0);
         check("idle_clr", 32'(cmd_clr), 32'h0);
         check("idle_sta", sta_dout, 32'h0);
         check("idle_cmd", cmd_din, 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
